// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the ALU control decoder and the execute unit.
interface alu_exec_unit_if #(parameter int WIDTH = 24);
   logic             start;
   logic [3:0]       operation;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             illegal;
   logic             busy;
   logic             done;

   modport master (
      output start, operation, a, b,
      input  result, zero, overflow, illegal, busy, done
   );

   modport slave (
      input  start, operation, a, b,
      output result, zero, overflow, illegal, busy, done
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered 24-bit execute unit: single-cycle logic/arith ops and a
// 24-iteration shift-add multiplier that holds Busy while it runs.
//
// state  | meaning
// S_IDLE | waiting for Start; non-MUL ops complete here in one cycle
// S_MUL  | shift-add iterating, Busy high, Start ignored
module alu_exec_unit #(
   parameter int WIDTH = 24
) (
   input  logic           i_clock,
   input  logic           i_reset,
   alu_exec_unit_if.slave bus
);
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0111;

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t           r_state,    w_state_nxt;
   logic [WIDTH-1:0] r_result,   w_result_nxt;
   logic             r_zero,     w_zero_nxt;
   logic             r_overflow, w_overflow_nxt;
   logic             r_illegal,  w_illegal_nxt;
   logic             r_busy,     w_busy_nxt;
   logic             r_done,     w_done_nxt;
   logic [WIDTH-1:0] r_mcand,    w_mcand_nxt;
   logic [WIDTH-1:0] r_mplier,   w_mplier_nxt;
   logic [WIDTH-1:0] r_acc,      w_acc_nxt;
   logic [4:0]       r_count,    w_count_nxt;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ovf;
   logic             w_alu_ill;
   logic [WIDTH-1:0] w_acc_step;

   assign w_sum      = bus.a + bus.b;
   assign w_diff     = bus.a - bus.b;
   assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      w_alu_ill = 1'b0;
      case (bus.operation)
         OP_AND: w_alu_res = bus.a & bus.b;
         OP_OR:  w_alu_res = bus.a | bus.b;
         OP_XOR: w_alu_res = bus.a ^ bus.b;
         OP_ADD: begin
            w_alu_res = w_sum;
            w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_diff;
            w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLL: w_alu_res = (bus.b[4:0] >= 5'd24) ? '0 : (bus.a << bus.b[4:0]);
         // MUL is never taken through this path; it only keeps the decode legal.
         OP_MUL: w_alu_res = '0;
         default: w_alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_result_nxt   = r_result;
      w_zero_nxt     = r_zero;
      w_overflow_nxt = r_overflow;
      w_illegal_nxt  = r_illegal;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_mcand_nxt    = r_mcand;
      w_mplier_nxt   = r_mplier;
      w_acc_nxt      = r_acc;
      w_count_nxt    = r_count;
      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (bus.start) begin
               if (bus.operation == OP_MUL) begin
                  w_mcand_nxt  = bus.a;
                  w_mplier_nxt = bus.b;
                  w_acc_nxt    = '0;
                  w_count_nxt  = '0;
                  w_busy_nxt   = 1'b1;
                  w_state_nxt  = S_MUL;
               end else begin
                  w_result_nxt   = w_alu_res;
                  w_zero_nxt     = (w_alu_res == '0);
                  w_overflow_nxt = w_alu_ovf;
                  w_illegal_nxt  = w_alu_ill;
                  w_done_nxt     = 1'b1;
               end
            end
         end
         S_MUL: begin
            w_acc_nxt    = w_acc_step;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_count_nxt  = r_count + 5'd1;
            if (r_count == 5'd23) begin
               w_result_nxt   = w_acc_step;
               w_zero_nxt     = (w_acc_step == '0);
               w_overflow_nxt = 1'b0;
               w_illegal_nxt  = 1'b0;
               w_busy_nxt     = 1'b0;
               w_done_nxt     = 1'b1;
               w_count_nxt    = '0;
               w_state_nxt    = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_illegal  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_result   <= w_result_nxt;
         r_zero     <= w_zero_nxt;
         r_overflow <= w_overflow_nxt;
         r_illegal  <= w_illegal_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_mcand    <= w_mcand_nxt;
         r_mplier   <= w_mplier_nxt;
         r_acc      <= w_acc_nxt;
         r_count    <= w_count_nxt;
      end
   end

   assign bus.result   = r_result;
   assign bus.zero     = r_zero;
   assign bus.overflow = r_overflow;
   assign bus.illegal  = r_illegal;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; inputs change and outputs are sampled on the falling edge.
module tb_alu_exec_unit;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   alu_exec_unit_if #(.WIDTH(24)) bus ();

   alu_exec_unit #(.WIDTH(24)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Called at a falling edge; returns one falling edge later with Start cleared.
   task automatic drive_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
      bus.start = 1'b1; bus.operation = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.operation = OP_AND; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if ({bus.result, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done} !== 29'h0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", {bus.result, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add_overflow();
      drive_op(OP_ADD, 24'h7FFFFF, 24'h000001);
      n_chk++; if (bus.result !== 24'h800000) begin n_err++; $display("FAIL add_ovf_result got=%h exp=800000", bus.result); end
      n_chk++; if ({bus.overflow, bus.zero, bus.illegal, bus.done} !== 4'b1001) begin n_err++; $display("FAIL add_ovf_flags got=%b exp=1001", {bus.overflow, bus.zero, bus.illegal, bus.done}); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL add_done_width got=%b exp=0", bus.done); end
      n_chk++; if (bus.result !== 24'h800000) begin n_err++; $display("FAIL add_result_hold got=%h exp=800000", bus.result); end
      drive_op(OP_SUB, 24'h800000, 24'h000001);
      n_chk++; if ({bus.result, bus.overflow} !== {24'h7FFFFF, 1'b1}) begin n_err++; $display("FAIL sub_ovf got=%h/%b exp=7fffff/1", bus.result, bus.overflow); end
   endtask

   task automatic test_back_to_back();
      bus.start = 1'b1; bus.operation = OP_SUB; bus.a = 24'h00ABCD; bus.b = 24'h00ABCD;
      @(negedge clk);
      n_chk++; if ({bus.result, bus.zero, bus.overflow, bus.done} !== {24'h0, 3'b101}) begin n_err++; $display("FAIL b2b_sub got=%h/%b%b%b exp=0/101", bus.result, bus.zero, bus.overflow, bus.done); end
      bus.operation = OP_SLT; bus.a = 24'hFFFFFF; bus.b = 24'h000001;
      @(negedge clk);
      bus.start = 1'b0;
      n_chk++; if ({bus.result, bus.zero, bus.done} !== {24'h000001, 2'b01}) begin n_err++; $display("FAIL b2b_slt got=%h/%b%b exp=000001/01", bus.result, bus.zero, bus.done); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_done_end got=%b exp=0", bus.done); end
   endtask

   task automatic test_logic_ops();
      drive_op(OP_AND, 24'hF0F0F0, 24'h0FF0FF);
      n_chk++; if (bus.result !== 24'h00F0F0) begin n_err++; $display("FAIL and got=%h exp=00f0f0", bus.result); end
      drive_op(OP_OR, 24'hF0F0F0, 24'h0F0F0F);
      n_chk++; if ({bus.result, bus.overflow} !== {24'hFFFFFF, 1'b0}) begin n_err++; $display("FAIL or got=%h/%b exp=ffffff/0", bus.result, bus.overflow); end
      drive_op(OP_XOR, 24'hFFFF00, 24'h0F0F0F);
      n_chk++; if (bus.result !== 24'hF0F00F) begin n_err++; $display("FAIL xor got=%h exp=f0f00f", bus.result); end
      drive_op(OP_SLT, 24'h000001, 24'hFFFFFF);
      n_chk++; if ({bus.result, bus.zero} !== {24'h0, 1'b1}) begin n_err++; $display("FAIL slt_false got=%h/%b exp=0/1", bus.result, bus.zero); end
   endtask

   task automatic test_shift_illegal();
      drive_op(OP_SLL, 24'h000001, 24'd23);
      n_chk++; if (bus.result !== 24'h800000) begin n_err++; $display("FAIL sll23 got=%h exp=800000", bus.result); end
      drive_op(OP_SLL, 24'h000001, 24'd24);
      n_chk++; if ({bus.result, bus.zero} !== {24'h0, 1'b1}) begin n_err++; $display("FAIL sll24 got=%h/%b exp=0/1", bus.result, bus.zero); end
      drive_op(OP_ADD, 24'h000004, 24'h000004);
      drive_op(4'b1111, 24'h123456, 24'h654321);
      n_chk++; if ({bus.result, bus.illegal, bus.zero, bus.overflow, bus.done} !== {24'h0, 4'b1101}) begin n_err++; $display("FAIL illegal got=%h/%b%b%b%b exp=0/1101", bus.result, bus.illegal, bus.zero, bus.overflow, bus.done); end
   endtask

   // Returns at the falling edge where Done is seen (or after the cycle budget).
   task automatic run_mul(input string nm, input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] exp, input bit inject);
      int  busy_cyc;
      bit  got_done;
      busy_cyc = 0; got_done = 1'b0;
      drive_op(OP_MUL, a, b);
      for (int c = 0; c < 40 && !got_done; c++) begin
         if (bus.busy) busy_cyc++;
         if (bus.done) got_done = 1'b1;
         else begin
            if (inject && c == 5) begin bus.start = 1'b1; bus.operation = OP_ADD; bus.a = 24'd1; bus.b = 24'd1; end
            else bus.start = 1'b0;
            @(negedge clk);
         end
      end
      n_chk++; if (got_done !== 1'b1) begin n_err++; $display("FAIL %s_done_seen got=%b exp=1", nm, got_done); end
      n_chk++; if (busy_cyc != 24) begin n_err++; $display("FAIL %s_busy_cycles got=%0d exp=24", nm, busy_cyc); end
      n_chk++; if ({bus.result, bus.busy, bus.overflow, bus.illegal} !== {exp, 3'b000}) begin n_err++; $display("FAIL %s_result got=%h/%b%b%b exp=%h/000", nm, bus.result, bus.busy, bus.overflow, bus.illegal, exp); end
   endtask

   task automatic test_mul();
      int extra;
      run_mul("mul_small", 24'h000123, 24'h000456, 24'h04EDC2, 1'b0);
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mul_done_width got=%b exp=0", bus.done); end
      run_mul("mul_neg", 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 1'b0);
      // Start in the Done cycle must be accepted.
      drive_op(OP_ADD, 24'h000010, 24'h000020);
      n_chk++; if ({bus.result, bus.done} !== {24'h000030, 1'b1}) begin n_err++; $display("FAIL start_on_done got=%h/%b exp=000030/1", bus.result, bus.done); end
      run_mul("mul_inject", 24'h000123, 24'h000456, 24'h04EDC2, 1'b1);
      extra = 0;
      repeat (5) begin @(negedge clk); if (bus.done) extra++; end
      n_chk++; if (extra != 0 || bus.result !== 24'h04EDC2) begin n_err++; $display("FAIL mul_inject_ignored got=%0d/%h exp=0/04edc2", extra, bus.result); end
   endtask

   task automatic test_reset_mid_mul();
      int extra;
      drive_op(OP_MUL, 24'h000123, 24'h000456);
      repeat (9) @(negedge clk);
      n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_mul_busy_before got=%b exp=1", bus.busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if ({bus.result, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done} !== 29'h0) begin n_err++; $display("FAIL rst_mul_outputs got=%h exp=0", {bus.result, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done}); end
      extra = 0;
      repeat (30) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
      n_chk++; if (extra != 0) begin n_err++; $display("FAIL rst_mul_no_done got=%0d exp=0", extra); end
      drive_op(OP_ADD, 24'd2, 24'd3);
      n_chk++; if ({bus.result, bus.done} !== {24'd5, 1'b1}) begin n_err++; $display("FAIL rst_then_add got=%h/%b exp=000005/1", bus.result, bus.done); end
   endtask

   task automatic test_reset_start_collide();
      rst = 1'b1;
      drive_op(OP_ADD, 24'd7, 24'd8);
      rst = 1'b0;
      n_chk++; if ({bus.result, bus.done} !== {24'd0, 1'b0}) begin n_err++; $display("FAIL rst_start_collide got=%h/%b exp=0/0", bus.result, bus.done); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_start_dropped got=%b exp=0", bus.done); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_back_to_back();
      test_logic_ops();
      test_shift_illegal();
      test_mul();
      test_reset_mid_mul();
      test_reset_start_collide();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute unit of the 24-bit CPU, sitting directly downstream of the ALU control decoder. It consumes the 4-bit `Operation` code plus two 24-bit operands and produces a registered result with Zero/Overflow flags. Single-cycle operations complete in one cycle. MUL runs as a 24-iteration shift-add sequence, and `Busy` stalls the pipeline while it runs.

## Interface
- `WIDTH`, 24: operand/result width; all behaviour below assumes 24.
- `Clock`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  request; sampled only when `Busy`=0.
- `Operation`  in  4  operation code from ALU control.
- `A`  in  24  operand A (rs).
- `B`  in  24  operand B (rt / immediate).
- `Result`  out  24  registered result; holds until the next accepted op.
- `Zero`  out  1  registered, `Result`==0.
- `Overflow`  out  1  registered signed overflow; ADD/SUB only, else 0.
- `Illegal`  out  1  registered, unknown `Operation` code.
- `Busy`  out  1  registered; high while a MUL iterates.
- `Done`  out  1  one-cycle pulse: `Result` and flags just updated.

## Operation
- Operation codes:
  - `0000` AND
  - `0001` OR
  - `0010` ADD
  - `1010` SUB (A−B)
  - `0011` SLT, signed: 1 if A<B, else 0
  - `0100` SLL: A << B[4:0]; shift ≥24 gives 0
  - `0101` MUL: low 24 bits of A*B
  - `0111` XOR
  - Any other code: `Result`=0, `Illegal`=1, `Zero`=1, `Overflow`=0.
- ADD/SUB: 24-bit wraparound. `Overflow` = operand signs agree (B inverted for SUB) and result sign differs.
- FSM has two states, IDLE and MUL.
  - IDLE, `Start`=1, non-MUL code: compute and register `Result` and flags, assert `Done` next cycle, stay in IDLE.
  - IDLE, `Start`=1, MUL code: latch multiplicand←A, multiplier←B, acc←0, count←0. Go to MUL with `Busy`←1. `Result` and flags keep their old values.
  - MUL, each cycle: if multiplier[0], acc←acc+multiplicand (mod 2^24). Then multiplicand<<=1, multiplier>>=1, count++.
  - MUL, on the iteration where count==23: `Result`←final acc, flags updated (`Overflow`=0, `Illegal`=0), `Busy`←0, `Done`←1, return to IDLE.
- No early termination; MUL is always 24 iterations.
- `Start` while `Busy`=1: ignored and not queued. Upstream must hold off.
- `Done` is set only by the update that writes `Result`. In every other cycle it is 0.

## Timing
- Reset values: `Result`=0, `Zero`=0, `Overflow`=0, `Illegal`=0, `Busy`=0, `Done`=0, state=IDLE, count=0.
- Non-MUL op: `Start` sampled at edge k. `Result`, flags and `Done` are valid in the cycle after edge k (latency 1). Back-to-back `Start` every cycle gives throughput 1/cycle.
- MUL: `Start` sampled at edge k.
  - `Busy`=1 in the 24 cycles following edges k..k+23.
  - `Result` updates at edge k+24, with `Done`=1 and `Busy`=0 in that same cycle.
  - Latency is 24 cycles.
- `Start` in the cycle `Done`=1 (MUL just finished, `Busy`=0) is accepted.
- `Reset` mid-MUL: abort at that edge. All outputs go to reset values, no `Done` is issued, and the partial product is discarded.
- `Reset` and `Start` in the same cycle: `Reset` wins and `Start` is dropped.
- Operands and `Operation` are sampled only at acceptance. Changing them during MUL has no effect.

## Test plan
- ADD A=0x7FFFFF, B=0x000001, `Start` 1 cycle -> next cycle `Result`=0x800000, `Overflow`=1, `Zero`=0, `Done`=1 for exactly 1 cycle.
- SUB A=B=0x00ABCD -> `Result`=0, `Zero`=1, `Overflow`=0. Then SLT A=0xFFFFFF, B=0x000001 -> `Result`=1. Issue both back-to-back with a `Done` pulse each cycle.
- MUL A=0x000123, B=0x000456 -> `Busy` high exactly 24 cycles, then `Result`=0x04EDC2 with `Done`. MUL 0xFFFFFF×0xFFFFFF -> `Result`=0x000001.
- During MUL, pulse `Start` with ADD 1+1 -> ignored; the MUL result is unchanged and only one `Done` pulse occurs.
- `Reset` at the 10th MUL cycle -> next cycle all outputs 0 and `Busy`=0, with no `Done`. Then ADD 2+3 -> `Result`=5.
- SLL A=0x000001, B=23 -> 0x800000, and B=24 -> 0. `Operation`=`1111` -> `Result`=0, `Illegal`=1, `Zero`=1.
